shift_sticky_pipe: RTL and testbench



---
 rtl/shift_sticky_pipe.sv | 156 +++++++++++++++
 tb/tb_shift_sticky_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_sticky_pipe.sv
// shift_sticky_pipe: two-stage pipelined right shifter with sticky output.
// Stage 1 does the coarse shift and the saturation check, and collects the
// bits shifted out. Stage 2 does the fine shift and finishes guard, round
// and sticky. Results hand off downstream through a valid/ready handshake.
// Optional feature macro: SHIFT_STICKY_GRS_EN (guard/round split).
module shift_sticky_pipe #(
  parameter int WID  = 64,
  parameter int AMTW = 8,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_v,
  output logic            i_rdy,
  input  logic [WID-1:0]  i_b,
  input  logic [AMTW-1:0] i_amt,
  input  logic            i_arith,
  input  logic [TAGW-1:0] i_tag,
  output logic            o_v,
  input  logic            o_rdy,
  output logic [WID-1:0]  o_res,
  output logic            o_guard,
  output logic            o_round,
  output logic            o_sticky,
  output logic [TAGW-1:0] o_tag
);

  localparam int LW = $clog2(WID);
  localparam int FB = LW / 2;

  logic v1, v2, rdy1, rdy2;

  // Stage 1 registers
  logic [WID-1:0]  c1;
  logic            g1, r1, s1, fill1;
  logic [FB-1:0]   f1;
  logic [TAGW-1:0] tag1;

  // Stage 1 next values
  logic            fill_n, sat_n, over_n;
  logic [LW:0]     sh_n;
  logic [WID-1:0]  c_n, lo_n;
  logic            g_n, r_n, s_n;
  logic [FB-1:0]   f_n;

  // Stage 2 next values
  logic [WID+1:0]  ext;
  logic [WID+1:0]  mask;
  logic [WID-1:0]  res_n;
  logic [1:0]      gr_n;
  logic            s2_n;

  assign rdy2  = !v2 || o_rdy;
  assign rdy1  = !v1 || rdy2;
  assign i_rdy = rdy1;
  assign o_v   = v2;

  // Coarse shift. A saturating amount is clamped to a shift of exactly WID, so
  // that the bits shifted out are the whole operand. For amounts beyond WID,
  // guard and round are then zeroed and all of the operand goes to sticky.
  always_comb begin
    fill_n = i_arith & i_b[WID-1];
    sat_n  = i_amt >= AMTW'(WID);
    over_n = i_amt > AMTW'(WID);
    sh_n   = sat_n ? (LW+1)'(WID) : {1'b0, i_amt[LW-1:FB], {FB{1'b0}}};
    c_n    = WID'($signed({fill_n, i_b}) >>> sh_n);
    lo_n   = WID'({i_b, {WID{1'b0}}} >> sh_n);
    f_n    = sat_n ? '0 : i_amt[FB-1:0];
    g_n    = 1'b0;
    r_n    = 1'b0;
    s_n    = |i_b;
    if (!over_n) begin
      g_n = lo_n[WID-1];
      r_n = lo_n[WID-2];
      s_n = |lo_n[WID-3:0];
    end
  end

  // Fine shift. Guard and round sit as two extra low bits below the coarse
  // result, so the fine shift moves them along with the data.
  always_comb begin
    ext   = {c1, g1, r1};
    res_n = WID'($signed({fill1, c1}) >>> f1);
    gr_n  = 2'(ext >> f1);
    mask  = ~({(WID+2){1'b1}} << f1);
    s2_n  = s1 | (|(ext & mask));
  end

  // Valid flags for both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (rdy1) v1 <= i_v;
      if (rdy2) v2 <= v1;
    end
  end

  // Stage 1 data: loads on an accepted input
  always_ff @(posedge clk) begin
    if (rst) begin
      c1    <= '0;
      g1    <= 1'b0;
      r1    <= 1'b0;
      s1    <= 1'b0;
      fill1 <= 1'b0;
      f1    <= '0;
      tag1  <= '0;
    end else if (i_v && rdy1) begin
      c1    <= c_n;
      g1    <= g_n;
      r1    <= r_n;
      s1    <= s_n;
      fill1 <= fill_n;
      f1    <= f_n;
      tag1  <= i_tag;
    end
  end

`ifdef SHIFT_STICKY_GRS_EN
  // Stage 2 data: loads when stage 1 hands over, guard/round kept separate
  always_ff @(posedge clk) begin
    if (rst) begin
      o_res    <= '0;
      o_guard  <= 1'b0;
      o_round  <= 1'b0;
      o_sticky <= 1'b0;
      o_tag    <= '0;
    end else if (v1 && rdy2) begin
      o_res    <= res_n;
      o_guard  <= gr_n[1];
      o_round  <= gr_n[0];
      o_sticky <= s2_n;
      o_tag    <= tag1;
    end
  end
`else
  assign o_guard = 1'b0;
  assign o_round = 1'b0;

  // Stage 2 data: loads when stage 1 hands over, sticky covers every lost bit
  always_ff @(posedge clk) begin
    if (rst) begin
      o_res    <= '0;
      o_sticky <= 1'b0;
      o_tag    <= '0;
    end else if (v1 && rdy2) begin
      o_res    <= res_n;
      o_sticky <= s2_n | (|gr_n);
      o_tag    <= tag1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_sticky_pipe.sv
// Directed bench for shift_sticky_pipe (WID=64, AMTW=8, TAGW=4).
// Expected guard/round/sticky follow SHIFT_STICKY_GRS_EN when defined.
module tb_shift_sticky_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_v;
  logic        i_rdy;
  logic [63:0] i_b;
  logic [7:0]  i_amt;
  logic        i_arith;
  logic [3:0]  i_tag;
  logic        o_v;
  logic        o_rdy;
  logic [63:0] o_res;
  logic        o_guard, o_round, o_sticky;
  logic [3:0]  o_tag;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  shift_sticky_pipe #(.WID(64), .AMTW(8), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .i_v(i_v), .i_rdy(i_rdy), .i_b(i_b), .i_amt(i_amt),
    .i_arith(i_arith), .i_tag(i_tag),
    .o_v(o_v), .o_rdy(o_rdy), .o_res(o_res),
    .o_guard(o_guard), .o_round(o_round), .o_sticky(o_sticky),
    .o_tag(o_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] b;
    logic [7:0]  n;
    logic        ar;
    logic [63:0] res;
    logic [2:0]  grs_on;   // {guard, round, sticky} with the split
    logic [2:0]  grs_off;  // {guard, round, sticky} without
  } vec_t;

  vec_t vecs[10];

  task automatic run_one(input int unsigned idx);
    logic [2:0] e;
`ifdef SHIFT_STICKY_GRS_EN
    e = vecs[idx].grs_on;
`else
    e = vecs[idx].grs_off;
`endif
    @(negedge clk);
    i_v = 1'b1; i_b = vecs[idx].b; i_amt = vecs[idx].n;
    i_arith = vecs[idx].ar; i_tag = 4'(idx);
    check($sformatf("v%0d_irdy", idx), 64'(i_rdy), 64'd1);
    @(negedge clk);
    i_v = 1'b0;
    check($sformatf("v%0d_ov_early", idx), 64'(o_v), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_ov", idx), 64'(o_v), 64'd1);
    check($sformatf("v%0d_res", idx), o_res, vecs[idx].res);
    check($sformatf("v%0d_guard", idx), 64'(o_guard), 64'(e[2]));
    check($sformatf("v%0d_round", idx), 64'(o_round), 64'(e[1]));
    check($sformatf("v%0d_sticky", idx), 64'(o_sticky), 64'(e[0]));
    check($sformatf("v%0d_tag", idx), 64'(o_tag), 64'(idx));
    @(negedge clk);
    check($sformatf("v%0d_drain", idx), 64'(o_v), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h8000000000000001, 8'd1,   1'b0, 64'h4000000000000000, 3'b100, 3'b001};
    vecs[1] = '{64'h00000000000000FF, 8'd0,   1'b0, 64'h00000000000000FF, 3'b000, 3'b000};
    vecs[2] = '{64'hF000000000000000, 8'd4,   1'b1, 64'hFF00000000000000, 3'b000, 3'b000};
    vecs[3] = '{64'h0000000000000001, 8'd200, 1'b0, 64'h0000000000000000, 3'b001, 3'b001};
    vecs[4] = '{64'h8000000000000000, 8'd64,  1'b1, 64'hFFFFFFFFFFFFFFFF, 3'b100, 3'b001};
    vecs[5] = '{64'h0000000000000007, 8'd2,   1'b0, 64'h0000000000000001, 3'b110, 3'b001};
    vecs[6] = '{64'h123456789ABCDEF0, 8'd12,  1'b0, 64'h000123456789ABCD, 3'b111, 3'b001};
    vecs[7] = '{64'h8000000000000000, 8'd63,  1'b1, 64'hFFFFFFFFFFFFFFFF, 3'b000, 3'b000};
    vecs[8] = '{64'h8000000000000000, 8'd65,  1'b0, 64'h0000000000000000, 3'b001, 3'b001};
    vecs[9] = '{64'h0000000000000180, 8'd8,   1'b0, 64'h0000000000000001, 3'b100, 3'b001};

    rst = 1'b1; i_v = 1'b0; i_b = '0; i_amt = '0; i_arith = 1'b0; i_tag = '0; o_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ov", 64'(o_v), 64'd0);
    check("rst_res", o_res, 64'd0);
    check("rst_guard", 64'(o_guard), 64'd0);
    check("rst_round", 64'(o_round), 64'd0);
    check("rst_sticky", 64'(o_sticky), 64'd0);
    check("rst_tag", 64'(o_tag), 64'd0);
    check("rst_irdy", 64'(i_rdy), 64'd1);

    for (int unsigned k = 0; k < 10; k++) run_one(k);

    // Backpressure: three back-to-back inputs while downstream is stalled
    o_rdy = 1'b0;
    for (int unsigned t = 1; t <= 3; t++) begin
      @(negedge clk);
      i_v = 1'b1; i_b = 64'(t); i_amt = 8'd0; i_arith = 1'b0; i_tag = 4'(t);
      check($sformatf("bp_irdy%0d", t), 64'(i_rdy), (t < 3) ? 64'd1 : 64'd0);
    end
    for (int unsigned s = 0; s < 3; s++) begin
      check($sformatf("bp_hold_ov%0d", s), 64'(o_v), 64'd1);
      check($sformatf("bp_hold_tag%0d", s), 64'(o_tag), 64'd1);
      check($sformatf("bp_hold_res%0d", s), o_res, 64'd1);
      check($sformatf("bp_hold_irdy%0d", s), 64'(i_rdy), 64'd0);
      @(negedge clk);
    end
    o_rdy = 1'b1;
    #1;
    check("bp_release_irdy", 64'(i_rdy), 64'd1);
    @(negedge clk);
    i_v = 1'b0;
    check("bp_out2_ov", 64'(o_v), 64'd1);
    check("bp_out2_tag", 64'(o_tag), 64'd2);
    @(negedge clk);
    check("bp_out3_ov", 64'(o_v), 64'd1);
    check("bp_out3_tag", 64'(o_tag), 64'd3);
    check("bp_out3_res", o_res, 64'd3);
    @(negedge clk);
    check("bp_empty", 64'(o_v), 64'd0);

    // Reset with two transactions in flight
    o_rdy = 1'b0;
    for (int unsigned t = 5; t <= 6; t++) begin
      @(negedge clk);
      i_v = 1'b1; i_b = 64'hABCD; i_amt = 8'd1; i_tag = 4'(t);
    end
    @(negedge clk);
    check("mf_full_ov", 64'(o_v), 64'd1);
    rst = 1'b1; i_tag = 4'd7;
    @(negedge clk);
    rst = 1'b0; i_v = 1'b0; o_rdy = 1'b1;
    check("mf_ov", 64'(o_v), 64'd0);
    check("mf_res", o_res, 64'd0);
    check("mf_sticky", 64'(o_sticky), 64'd0);
    check("mf_tag", 64'(o_tag), 64'd0);
    check("mf_irdy", 64'(i_rdy), 64'd1);
    for (int unsigned s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("mf_quiet%0d", s), 64'(o_v), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
